// File: rtl/lh_filter_pkg.sv
// Shared types and helpers for the LH filter control blocks.
package lh_filter_pkg;

    localparam int TAU_W          = 6;
    localparam int TAU_BYPASS_MIN = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    // Any code with a nonzero top pair selects filter pass-through.
    function automatic logic is_bypass(input logic [TAU_W-1:0] tau);
        return tau[TAU_W-1:TAU_W-2] != 2'b00;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Down-counter that times how long each tau code is held; expire marks the last cycle.
module dwell_counter #(
    parameter int DWELL_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               expire
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == DWELL_W'(1));

endmodule

// File: rtl/lh_tau_ramp_ctrl.sv
// Steps the LH filter tau from a start code to a target code, one code per dwell period.
// Optional filter reset pulse on each accepted start: define LH_TAU_RAMP_FILT_RST_EN.
module lh_tau_ramp_ctrl
    import lh_filter_pkg::*;
#(
    parameter int               DWELL_W = 32,
    parameter logic [TAU_W-1:0] TAU_RST = TAU_W'(TAU_BYPASS_MIN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [TAU_W-1:0]   tau_start,
    input  logic [TAU_W-1:0]   tau_target,
    input  logic [DWELL_W-1:0] dwell,
    output logic [TAU_W-1:0]   tau_out,
    output logic               filt_rst,
    output logic               busy,
    output logic               done,
    output state_t             state
);

`ifdef LH_TAU_RAMP_FILT_RST_EN
    localparam logic FILT_RST_EN = 1'b1;
`else
    localparam logic FILT_RST_EN = 1'b0;
`endif

    // Handshake: start is a one-cycle request honoured only in IDLE (abort wins);
    // done pulses once when tau_out reaches the target, with state already IDLE.
    state_t             state_q, state_d;
    logic [TAU_W-1:0]   tau_q, tau_d, tgt_q, tgt_d, step_tau;
    logic [DWELL_W-1:0] dwl_q, dwl_d, dwell_eff, cnt_val;
    logic               done_q, done_d, frst_q, frst_d;
    logic               cnt_load, expire;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign step_tau  = (tau_q < tgt_q) ? tau_q + 1'b1 : tau_q - 1'b1;

    dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (state_q == RAMP),
        .expire   (expire)
    );

    always_comb begin
        state_d  = state_q;
        tau_d    = tau_q;
        tgt_d    = tgt_q;
        dwl_d    = dwl_q;
        done_d   = 1'b0;
        frst_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = dwl_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    tgt_d    = tau_target;
                    dwl_d    = dwell_eff;
                    cnt_load = 1'b1;
                    cnt_val  = dwell_eff;
                    frst_d   = FILT_RST_EN;
                    if (is_bypass(tau_start) || is_bypass(tau_target)) begin
                        tau_d  = tau_target;
                        done_d = 1'b1;
                    end else begin
                        tau_d = tau_start;
                        if (tau_start == tau_target) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RAMP;
                        end
                    end
                end
            end
            RAMP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (expire) begin
                    tau_d    = step_tau;
                    cnt_load = 1'b1;
                    if (step_tau == tgt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tau_q   <= TAU_RST;
            tgt_q   <= TAU_RST;
            dwl_q   <= DWELL_W'(1);
            done_q  <= 1'b0;
            frst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tau_q   <= tau_d;
            tgt_q   <= tgt_d;
            dwl_q   <= dwl_d;
            done_q  <= done_d;
            frst_q  <= frst_d;
        end
    end

    assign tau_out  = tau_q;
    assign filt_rst = frst_q;
    assign busy     = (state_q == RAMP);
    assign done     = done_q;
    assign state    = state_q;

endmodule

// File: tb/tb_lh_tau_ramp_ctrl.sv
// Self-checking bench for lh_tau_ramp_ctrl: table of ramps plus abort/reset/back-to-back sequences.
module tb_lh_tau_ramp_ctrl;
    import lh_filter_pkg::*;

`ifdef LH_TAU_RAMP_FILT_RST_EN
    localparam logic FRST = 1'b1;
`else
    localparam logic FRST = 1'b0;
`endif

    // clock / reset
    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [5:0]  tau_start, tau_target;
    logic [31:0] dwell;
    logic [5:0]  tau_out;
    logic        filt_rst, busy, done;
    state_t      state;

    always #5 clk = ~clk;

    lh_tau_ramp_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .tau_start  (tau_start),
        .tau_target (tau_target),
        .dwell      (dwell),
        .tau_out    (tau_out),
        .filt_rst   (filt_rst),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    // scoreboard: {tau_out, busy, done, filt_rst} expected per cycle
    logic [8:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0]  s;
        logic [5:0]  t;
        logic [31:0] d;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model from the timing description: T+1+k, code = s + dir*(k/D)
    task automatic push_model(input logic [5:0] s, input logic [5:0] t, input logic [31:0] d);
        int dd, n, dir, code;
        logic [5:0] tau_e;
        if (s >= 6'd16 || t >= 6'd16) begin
            exp_q.push_back({t, 1'b0, 1'b1, FRST});
            exp_q.push_back({t, 1'b0, 1'b0, 1'b0});
        end else if (s == t) begin
            exp_q.push_back({s, 1'b0, 1'b1, FRST});
            exp_q.push_back({s, 1'b0, 1'b0, 1'b0});
        end else begin
            dd  = (d == 0) ? 1 : int'(d);
            dir = (s < t) ? 1 : -1;
            n   = (s < t) ? int'(t) - int'(s) : int'(s) - int'(t);
            for (int k = 0; k <= n * dd; k++) begin
                code  = int'(s) + dir * (k / dd);
                tau_e = code[5:0];
                exp_q.push_back({tau_e, (k < n * dd), (k == n * dd), (k == 0) ? FRST : 1'b0});
            end
            exp_q.push_back({t, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic drive_start(input logic [5:0] s, input logic [5:0] t, input logic [31:0] d);
        tau_start  = s;
        tau_target = t;
        dwell      = d;
        start      = 1'b1;
    endtask

    // advance one cycle, release pulses, compare against head of queue
    task automatic tick(input string name);
        logic [8:0] e;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty at %0t", name, $time);
        end else begin
            e = exp_q.pop_front();
            check(name, {23'd0, tau_out, busy, done, filt_rst}, {23'd0, e});
        end
    endtask

    task automatic pump(input string name);
        for (int i = 0; i < 2000 && exp_q.size() > 0; i++) tick(name);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        tau_start = 6'd0; tau_target = 6'd0; dwell = 32'd0;
        vecs[0] = '{6'd2,  6'd5,  32'd4};
        vecs[1] = '{6'd9,  6'd6,  32'd0};
        vecs[2] = '{6'd3,  6'd16, 32'd2};
        vecs[3] = '{6'd7,  6'd7,  32'd3};
        vecs[4] = '{6'd20, 6'd3,  32'd2};
        vecs[5] = '{6'd0,  6'd15, 32'd1};
        vecs[6] = '{6'd15, 6'd14, 32'd2};
        vecs[7] = '{6'd63, 6'd63, 32'd0};
        for (int i = 8; i < 10; i++) begin
            vecs[i].s = 6'($urandom_range(0, 15));
            vecs[i].t = 6'($urandom_range(0, 15));
            vecs[i].d = 32'($urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_tau", {26'd0, tau_out}, 32'd16);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_filt_rst", {31'd0, filt_rst}, 32'd0);
        check("rst_state", {31'd0, state}, {31'd0, IDLE});

        // table-driven ramps
        for (int i = 0; i < 10; i++) begin
            push_model(vecs[i].s, vecs[i].t, vecs[i].d);
            drive_start(vecs[i].s, vecs[i].t, vecs[i].d);
            pump($sformatf("vec%0d", i));
        end

        // abort at tau=4 on ramp 0->10 dwell 3, with an ignored mid-ramp start
        for (int k = 0; k <= 12; k++) exp_q.push_back({6'(k / 3), k < 13, 1'b0, (k == 0) ? FRST : 1'b0});
        for (int k = 0; k < 4; k++) exp_q.push_back({6'd4, 1'b0, 1'b0, 1'b0});
        drive_start(6'd0, 6'd10, 32'd3);
        for (int k = 0; k <= 12; k++) begin
            tick("abort_ramp");
            if (k == 4) drive_start(6'd30, 6'd1, 32'd0);
            if (k == 5) begin tau_start = 6'd12; tau_target = 6'd1; dwell = 32'd9; end
            if (k == 12) abort = 1'b1;
        end
        pump("abort_hold");
        check("abort_state", {31'd0, state}, {31'd0, IDLE});

        // reset mid-ramp, then a normal ramp
        drive_start(6'd2, 6'd9, 32'd2);
        repeat (5) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_tau", {26'd0, tau_out}, 32'd16);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_filt_rst", {31'd0, filt_rst}, 32'd0);
        push_model(6'd1, 6'd3, 32'd2);
        drive_start(6'd1, 6'd3, 32'd2);
        pump("post_rst_ramp");

        // start accepted in the done cycle
        exp_q.push_back({6'd2, 1'b1, 1'b0, FRST});
        exp_q.push_back({6'd3, 1'b0, 1'b1, 1'b0});
        drive_start(6'd2, 6'd3, 32'd1);
        tick("b2b_first");
        tick("b2b_done");
        push_model(6'd5, 6'd4, 32'd1);
        drive_start(6'd5, 6'd4, 32'd1);
        pump("b2b_second");

        // abort together with an IDLE start drops the start
        exp_q.push_back({6'd4, 1'b0, 1'b0, 1'b0});
        exp_q.push_back({6'd4, 1'b0, 1'b0, 1'b0});
        drive_start(6'd1, 6'd8, 32'd1);
        abort = 1'b1;
        pump("abort_vs_start");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
